// File: rtl/led_pattern_counter.sv
// led_pattern_counter
//   Prescaled LED pattern driver. A prescaler divides clk down to the tick
//   rate (DIV = CLK_FREQ/TICK_HZ, minimum 1); each tick steps one of four
//   patterns shown on the LED bus: binary, Gray, rotating one-hot and
//   bouncing one-hot.
//
// Optional build macro: LED_PWM_EN adds a duty input and a free-running
//   4-bit PWM counter that gates the LED bus (on while pwm_cnt < duty).
//
// Ports:
//   clk       in   system clock
//   rst_n     in   asynchronous active-low reset
//   en        in   1 = prescaler and pattern run, 0 = freeze
//   mode      in   00 binary, 01 Gray, 10 rotate one-hot, 11 bounce one-hot
//   dir       in   0 = up/left (toward MSB), 1 = down/right (ignored in 11)
//   load      in   synchronous load strobe (overrides en)
//   load_val  in   value loaded into the binary counter
//   duty      in   PWM duty, 0..15 (LED_PWM_EN builds only)
//   leds      out  registered LED drive
//   tick      out  registered one-cycle pulse per pattern step
module led_pattern_counter #(
    parameter int unsigned CLK_FREQ = 10,
    parameter int unsigned TICK_HZ  = 2,
    parameter int unsigned WIDTH    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
`ifdef LED_PWM_EN
    input  logic [3:0]       duty,
`endif
    output logic [WIDTH-1:0] leds,
    output logic             tick
);

    localparam int unsigned DIV_RAW  = CLK_FREQ / TICK_HZ;
    localparam int unsigned DIV      = (DIV_RAW == 0) ? 1 : DIV_RAW;
    localparam logic [31:0] DIV_LAST = 32'(DIV - 1);
    localparam int unsigned POS_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [POS_W-1:0] POS_MAX = POS_W'(WIDTH - 1);

    typedef enum logic {
        BOUNCE_UP   = 1'b0,
        BOUNCE_DOWN = 1'b1
    } bounce_e;

    typedef enum logic [1:0] {
        MODE_BIN    = 2'b00,
        MODE_GRAY   = 2'b01,
        MODE_ROT    = 2'b10,
        MODE_BOUNCE = 2'b11
    } mode_e;

    mode_e            mode_sel;
    logic [31:0]      presc, presc_d;
    logic [WIDTH-1:0] bin_cnt, bin_d;
    logic [POS_W-1:0] pos, pos_d;
    bounce_e          bdir, bdir_d;
    logic             tick_d;
    logic [WIDTH-1:0] pattern, leds_d;

    assign mode_sel = mode_e'(mode);

    // Next-state: load > en > hold. Only the active pattern's state steps.
    always_comb begin
        presc_d = presc;
        bin_d   = bin_cnt;
        pos_d   = pos;
        bdir_d  = bdir;
        tick_d  = 1'b0;
        if (load) begin
            bin_d   = load_val;
            pos_d   = '0;
            bdir_d  = BOUNCE_UP;
            presc_d = '0;
        end else if (en) begin
            if (presc == DIV_LAST) begin
                presc_d = '0;
                tick_d  = 1'b1;
                case (mode_sel)
                    MODE_BIN, MODE_GRAY: begin
                        bin_d = dir ? (bin_cnt - 1'b1) : (bin_cnt + 1'b1);
                    end
                    MODE_ROT: begin
                        if (dir)
                            pos_d = (pos == '0) ? POS_MAX : (pos - 1'b1);
                        else
                            pos_d = (pos == POS_MAX) ? '0 : (pos + 1'b1);
                    end
                    default: begin
                        // Reversal happens on the step leaving an endpoint,
                        // so each endpoint stays lit for exactly one tick.
                        if (WIDTH > 1) begin
                            if (bdir == BOUNCE_UP) begin
                                if (pos == POS_MAX) begin
                                    bdir_d = BOUNCE_DOWN;
                                    pos_d  = pos - 1'b1;
                                end else begin
                                    pos_d  = pos + 1'b1;
                                end
                            end else begin
                                if (pos == '0) begin
                                    bdir_d = BOUNCE_UP;
                                    pos_d  = pos + 1'b1;
                                end else begin
                                    pos_d  = pos - 1'b1;
                                end
                            end
                        end
                    end
                endcase
            end else begin
                presc_d = presc + 32'd1;
            end
        end
    end

    // Decode from the registered state, so leds lag the state by one clock.
    always_comb begin
        pattern = '0;
        case (mode_sel)
            MODE_BIN:  pattern = bin_cnt;
            MODE_GRAY: pattern = bin_cnt ^ (bin_cnt >> 1);
            default:   pattern[pos] = 1'b1;
        endcase
    end

`ifdef LED_PWM_EN
    logic [3:0] pwm_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pwm_cnt <= '0;
        else        pwm_cnt <= pwm_cnt + 4'd1;
    end

    assign leds_d = pattern & {WIDTH{pwm_cnt < duty}};
`else
    assign leds_d = pattern;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc   <= '0;
            bin_cnt <= '0;
            pos     <= '0;
            bdir    <= BOUNCE_UP;
            tick    <= 1'b0;
            leds    <= '0;
        end else begin
            presc   <= presc_d;
            bin_cnt <= bin_d;
            pos     <= pos_d;
            bdir    <= bdir_d;
            tick    <= tick_d;
            leds    <= leds_d;
        end
    end

endmodule

// File: tb/tb_led_pattern_counter.sv
// tb_led_pattern_counter
//   Directed bench for led_pattern_counter at default parameters
//   (DIV = 5, WIDTH = 8). Inputs change and outputs are sampled on the
//   falling edge; expected values are hand-derived from the edge count.
module tb_led_pattern_counter;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [1:0] mode;
    logic       dir;
    logic       load;
    logic [7:0] load_val;
    logic [7:0] leds;
    logic       tick;
`ifdef LED_PWM_EN
    logic [3:0] duty;
`endif

    int unsigned checks   = 0;
    int unsigned failures = 0;

    led_pattern_counter #(
        .CLK_FREQ(10),
        .TICK_HZ (2),
        .WIDTH   (8)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .mode    (mode),
        .dir     (dir),
        .load    (load),
        .load_val(load_val),
`ifdef LED_PWM_EN
        .duty    (duty),
`endif
        .leds    (leds),
        .tick    (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic clk_n(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [7:0] exp_led;
`ifdef LED_PWM_EN
        duty = 4'hF;
`endif
        rst_n    = 1'b0;
        en       = 1'b1;
        mode     = 2'b00;
        dir      = 1'b0;
        load     = 1'b0;
        load_val = 8'h00;

        // Reset state
        clk_n(2);
        check("reset_leds", 32'(leds), 32'h00);
        check("reset_tick", 32'(tick), 32'h0);
        rst_n = 1'b1;

        // Binary up: tick on edge 5, leds follow one clock later
        for (int i = 0; i < 4; i++) begin
            clk_n(1);
            check("bin_pre_tick", 32'(tick), 32'h0);
        end
        clk_n(1);
        check("bin_tick1", 32'(tick), 32'h1);
        check("bin_led_before_step", 32'(leds), 32'h00);
        clk_n(1);
        check("bin_tick1_pulse", 32'(tick), 32'h0);
        check("bin_led1", 32'(leds), 32'h01);
        clk_n(5);
        check("bin_led2", 32'(leds), 32'h02);
        clk_n(1265);
        check("bin_led_ff", 32'(leds), 32'hFF);
        clk_n(5);
        check("bin_wrap", 32'(leds), 32'h00);

        // Binary down from reset, then freeze with en=0
        rst_n = 1'b0;
        dir   = 1'b1;
        clk_n(2);
        rst_n = 1'b1;
        clk_n(6);
        check("down_led_ff", 32'(leds), 32'hFF);
        clk_n(5);
        check("down_led_fe", 32'(leds), 32'hFE);
        en = 1'b0;
        clk_n(12);
        check("freeze_leds", 32'(leds), 32'hFE);
        check("freeze_tick", 32'(tick), 32'h0);
        en = 1'b1;
        clk_n(3);
        check("resume_no_tick", 32'(tick), 32'h0);
        clk_n(1);
        check("resume_tick", 32'(tick), 32'h1);
        clk_n(1);
        check("resume_led_fd", 32'(leds), 32'hFD);

        // Load 0x05 in Gray mode
        load     = 1'b1;
        load_val = 8'h05;
        mode     = 2'b01;
        dir      = 1'b0;
        clk_n(1);
        load = 1'b0;
        check("load_tick", 32'(tick), 32'h0);
        clk_n(1);
        check("gray_of_5", 32'(leds), 32'h07);
        clk_n(4);
        check("gray_tick", 32'(tick), 32'h1);
        clk_n(1);
        check("gray_of_6", 32'(leds), 32'h05);

        // Rotate one-hot: pos is 0 after the load
        mode = 2'b10;
        dir  = 1'b1;
        clk_n(1);
        check("rot_start", 32'(leds), 32'h01);
        clk_n(4);
        check("rot_wrap_down", 32'(leds), 32'h80);
        clk_n(5);
        check("rot_down", 32'(leds), 32'h40);
        dir = 1'b0;
        clk_n(5);
        check("rot_up", 32'(leds), 32'h80);
        clk_n(5);
        check("rot_wrap_up", 32'(leds), 32'h01);

        // Bounce one-hot (dir ignored)
        load     = 1'b1;
        load_val = 8'h00;
        mode     = 2'b11;
        dir      = 1'b1;
        clk_n(1);
        load = 1'b0;
        clk_n(1);
        check("bounce_start", 32'(leds), 32'h01);
        exp_led = 8'h01;
        for (int i = 0; i < 7; i++) begin
            exp_led = exp_led << 1;
            clk_n(5);
            check("bounce_up", 32'(leds), 32'(exp_led));
        end
        for (int i = 0; i < 7; i++) begin
            exp_led = exp_led >> 1;
            clk_n(5);
            check("bounce_down", 32'(leds), 32'(exp_led));
        end
        clk_n(5);
        check("bounce_rebound", 32'(leds), 32'h02);

        // Reset mid-count at presc=3, leds=0x2A
        load     = 1'b1;
        load_val = 8'h2A;
        mode     = 2'b00;
        dir      = 1'b0;
        clk_n(1);
        load = 1'b0;
        clk_n(3);
        check("pre_reset_leds", 32'(leds), 32'h2A);
        rst_n = 1'b0;
        #1;
        check("async_reset_leds", 32'(leds), 32'h00);
        check("async_reset_tick", 32'(tick), 32'h0);
        clk_n(1);
        rst_n = 1'b1;
        clk_n(4);
        check("post_reset_no_tick", 32'(tick), 32'h0);
        clk_n(1);
        check("post_reset_tick", 32'(tick), 32'h1);
        clk_n(1);
        check("post_reset_led", 32'(leds), 32'h01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
